// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered FIR coefficient bank behind a 16-bit
// Wishbone slave. Software fills the shadow bank. A COMMIT request arms a
// copy of the whole bank into the active bank. The copy happens on the next
// sample strobe, so the filter never sees a half-written coefficient set.
//
// Bus handshake: an access is accepted when wb_stb & wb_cyc are high and
// neither wb_ack nor wb_err is currently high (that is, neither was asserted
// by the previous edge). Exactly one of wb_ack/wb_err pulses for one cycle on
// the cycle after the accept. Register side effects happen on the accept
// edge. wb_rd_dat is non-zero only in a read-ack cycle.
module fir_coeff_bank #(
    parameter int                NUM_TAPS   = 33,
    parameter int                COEF_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter logic [COEF_W-1:0] CENTER_RST = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          wb_adr,
    output logic [COEF_W-1:0]          wb_rd_dat,
    input  logic [COEF_W-1:0]          wb_wr_dat,
    input  logic                       wb_we,
    input  logic [COEF_W/8-1:0]        wb_sel,
    input  logic                       wb_stb,
    input  logic                       wb_cyc,
    output logic                       wb_ack,
    output logic                       wb_err,
    input  logic                       sample_stb,
    output logic [NUM_TAPS*COEF_W-1:0] coeff_flat,
    output logic                       coeff_update,
    output logic [COEF_W-1:0]          testvec_sel
);

    localparam int SEL_W  = COEF_W / 8;
    localparam int CENTER = NUM_TAPS / 2;

    localparam logic [ADDR_W-1:0] SHADOW_END  = ADDR_W'(NUM_TAPS);
    localparam logic [ADDR_W-1:0] ACTIVE_BASE = ADDR_W'(64);
    localparam logic [ADDR_W-1:0] ACTIVE_END  = ADDR_W'(64 + NUM_TAPS);
    localparam logic [ADDR_W-1:0] CTRL_ADR    = ADDR_W'(8'hC0);
    localparam logic [ADDR_W-1:0] STATUS_ADR  = ADDR_W'(8'hC1);
    localparam logic [ADDR_W-1:0] TESTVEC_ADR = ADDR_W'(8'hC2);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state;
    logic [7:0]        commit_cnt;
    logic [COEF_W-1:0] shadow [NUM_TAPS];
    logic [COEF_W-1:0] active [NUM_TAPS];

    logic              pending;
    logic              accept;
    logic              hit_shadow;
    logic              hit_active;
    logic              bad;
    logic [COEF_W-1:0] rd_mux;
    logic              ctrl_wr;
    logic              commit_req;
    logic              abort_req;
    logic              shadow_wr;
    logic              testvec_wr;
    logic [5:0]        tap_idx;

    assign pending = (state == PENDING);
    assign tap_idx = wb_adr[5:0];

    // Keep the bytes whose enable is clear, take the new data elsewhere.
    function automatic logic [COEF_W-1:0] byte_merge(
        input logic [COEF_W-1:0] old_val,
        input logic [COEF_W-1:0] new_val,
        input logic [SEL_W-1:0]  sel
    );
        logic [COEF_W-1:0] r;
        r = old_val;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel[b]) begin
                r[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Address decode, legality check and read mux for the access now on the bus.
    always_comb begin
        accept     = wb_stb && wb_cyc && !wb_ack && !wb_err;
        hit_shadow = (wb_adr < SHADOW_END);
        hit_active = (wb_adr >= ACTIVE_BASE) && (wb_adr < ACTIVE_END);
        bad        = 1'b0;
        rd_mux     = '0;
        if (hit_shadow) begin
            rd_mux = shadow[tap_idx];
            bad    = wb_we && pending;
        end else if (hit_active) begin
            rd_mux = active[tap_idx];
            bad    = wb_we;
        end else if (wb_adr == CTRL_ADR) begin
            rd_mux = '0;
        end else if (wb_adr == STATUS_ADR) begin
            rd_mux = {commit_cnt, 7'b0, pending};
            bad    = wb_we;
        end else if (wb_adr == TESTVEC_ADR) begin
            rd_mux = testvec_sel;
        end else begin
            bad = 1'b1;
        end
        shadow_wr  = accept && !bad && wb_we && hit_shadow;
        testvec_wr = accept && !bad && wb_we && (wb_adr == TESTVEC_ADR);
        ctrl_wr    = accept && !bad && wb_we && (wb_adr == CTRL_ADR) && wb_sel[0];
        commit_req = ctrl_wr && wb_wr_dat[0] && !wb_wr_dat[1];
        abort_req  = ctrl_wr && wb_wr_dat[1];
    end

    // Bus responses, shadow bank writes and the test-vector register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack      <= 1'b0;
            wb_err      <= 1'b0;
            wb_rd_dat   <= '0;
            testvec_sel <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= (k == CENTER) ? CENTER_RST : '0;
            end
        end else begin
            wb_ack    <= 1'b0;
            wb_err    <= 1'b0;
            wb_rd_dat <= '0;
            if (accept) begin
                if (bad) begin
                    wb_err <= 1'b1;
                end else begin
                    wb_ack <= 1'b1;
                    if (!wb_we) begin
                        wb_rd_dat <= rd_mux;
                    end
                end
            end
            if (shadow_wr) begin
                shadow[tap_idx] <= byte_merge(shadow[tap_idx], wb_wr_dat, wb_sel);
            end
            if (testvec_wr) begin
                testvec_sel <= byte_merge(testvec_sel, wb_wr_dat, wb_sel);
            end
        end
    end

    // Commit FSM: arm on COMMIT, copy shadow to active on a later sample strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            commit_cnt   <= '0;
            coeff_update <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                active[k] <= (k == CENTER) ? CENTER_RST : '0;
            end
        end else begin
            coeff_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit_req) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (abort_req) begin
                        state <= IDLE;
                    end else if (sample_stb) begin
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            active[k] <= shadow[k];
                        end
                        coeff_update <= 1'b1;
                        commit_cnt   <= commit_cnt + 8'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flatten the active bank for the filter datapath.
    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_flat
        assign coeff_flat[g*COEF_W +: COEF_W] = active[g];
    end

endmodule
